// File: rtl/branch_ctrl_pkg.sv
// Shared types and defaults for the branch controller: FSM states, branch
// condition encodings, default widths and the condition-evaluation helper.
package branch_ctrl_pkg;

  localparam int unsigned DEF_DATA_W       = 16;
  localparam int unsigned DEF_PC_W         = 16;
  localparam int unsigned DEF_FLUSH_CYCLES = 2;
  // Flush counter width; covers the full 1..15 flush-length range.
  localparam int unsigned CNT_W            = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RESOLVE  = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'b00,
    COND_Z      = 2'b01,
    COND_NZ     = 2'b10,
    COND_NEVER  = 2'b11
  } cond_e;

  // True when a branch with this condition is taken under flag z.
  function automatic logic cond_taken(input cond_e cond, input logic z);
    logic taken;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_Z:      taken = z;
      COND_NZ:     taken = ~z;
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_ctrl_zd.sv
// Zero detector: flags an all-zero ALU result. Purely combinational.
module branch_ctrl_zd
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned W = DEF_DATA_W
) (
  input  logic [W-1:0] data_i,
  output logic         zero_c
);

  assign zero_c = (data_i == '0);

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: holds the Z flag, resolves decode branch requests against
// it, and for taken branches runs a PC-load handshake followed by a fixed flush.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned PC_W         = DEF_PC_W,
  parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_valid,
  input  logic              flag_we,
  input  logic              flag_busy,
  input  logic              br_req,
  input  logic [1:0]        br_cond,
  input  logic [PC_W-1:0]   br_target,
  input  logic              fetch_ready,
  output logic              z_flag,
  output logic              stall,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_target,
  output logic              flush,
  output logic              br_ack
);

  state_e             state_q, state_d;
  cond_e              cond_q, cond_d;
  logic [PC_W-1:0]    target_q, target_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               z_q, z_d;
  logic               zero_c;
  logic               br_ack_c;
  logic               stall_q, pc_load_q, flush_q;

  branch_ctrl_zd #(
    .W (DATA_W)
  ) zd (
    .data_i (alu_result),
    .zero_c (zero_c)
  );

  // Flag update is independent of the branch FSM.
  assign z_d = (alu_valid && flag_we) ? zero_c : z_q;

  // Next-state and retire-pulse logic.
  always_comb begin
    state_d  = state_q;
    cond_d   = cond_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    br_ack_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (br_req) begin
          cond_d   = cond_e'(br_cond);
          target_d = br_target;
          state_d  = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        // flag_busy holds every condition here so resolve timing is uniform.
        if (!flag_busy) begin
          if (cond_taken(cond_q, z_q)) begin
            state_d = ST_REDIRECT;
          end else begin
            br_ack_c = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_REDIRECT: begin
        if (fetch_ready) begin
          cnt_d   = CNT_W'(FLUSH_CYCLES);
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          br_ack_c = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cond_q    <= COND_ALWAYS;
      target_q  <= '0;
      cnt_q     <= '0;
      z_q       <= 1'b0;
      stall_q   <= 1'b0;
      pc_load_q <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cond_q    <= cond_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      z_q       <= z_d;
      stall_q   <= (state_d != ST_IDLE);
      pc_load_q <= (state_d == ST_REDIRECT);
      flush_q   <= (state_d == ST_FLUSH);
    end
  end

  assign z_flag    = z_q;
  assign stall     = stall_q;
  assign pc_load   = pc_load_q;
  assign pc_target = target_q;
  assign flush     = flush_q;
  // A reset cycle abandons the branch, so it never retires.
  assign br_ack    = br_ack_c && !reset;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_branch_ctrl;

  localparam int unsigned FL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] alu_result;
  logic        alu_valid, flag_we, flag_busy, br_req, fetch_ready;
  logic [1:0]  br_cond;
  logic [15:0] br_target;
  logic        z_flag, stall, pc_load, flush, br_ack;
  logic [15:0] pc_target;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: a branch in flight and which phase it is in.
  bit          m_z;
  bit          m_active;
  bit          m_wait_res;
  bit          m_wait_fetch;
  int          m_flush_left;
  logic [1:0]  m_cond;
  logic [15:0] m_target;

  branch_ctrl #(
    .DATA_W       (16),
    .PC_W         (16),
    .FLUSH_CYCLES (FL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_result  (alu_result),
    .alu_valid   (alu_valid),
    .flag_we     (flag_we),
    .flag_busy   (flag_busy),
    .br_req      (br_req),
    .br_cond     (br_cond),
    .br_target   (br_target),
    .fetch_ready (fetch_ready),
    .z_flag      (z_flag),
    .stall       (stall),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .flush       (flush),
    .br_ack      (br_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit takes(input logic [1:0] c, input bit z);
    return (c == 2'd0) || (c == 2'd1 && z) || (c == 2'd2 && !z);
  endfunction

  task automatic model_reset();
    m_z = 0; m_active = 0; m_wait_res = 0; m_wait_fetch = 0;
    m_flush_left = 0; m_cond = 2'd0; m_target = 16'h0;
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input bit rst, input bit av, input bit fw, input logic [15:0] res,
                      input bit busy, input bit req, input logic [1:0] cond,
                      input logic [15:0] tgt, input bit rdy);
    bit exp_ack;
    bit new_z;
    reset = rst; alu_valid = av; flag_we = fw; alu_result = res;
    flag_busy = busy; br_req = req; br_cond = cond; br_target = tgt; fetch_ready = rdy;
    exp_ack = !rst && ((m_wait_res && !busy && !takes(m_cond, m_z)) || (m_flush_left == 1));
    @(negedge clk);
    chk("z_flag",    32'(z_flag),    32'(m_z));
    chk("stall",     32'(stall),     32'(m_active));
    chk("pc_load",   32'(pc_load),   32'(m_wait_fetch));
    chk("flush",     32'(flush),     32'(m_flush_left > 0));
    chk("pc_target", 32'(pc_target), 32'(m_target));
    chk("br_ack",    32'(br_ack),    32'(exp_ack));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      new_z = (av && fw) ? (res == 16'h0) : m_z;
      if (!m_active) begin
        if (req) begin
          m_active = 1; m_wait_res = 1; m_cond = cond; m_target = tgt;
        end
      end else if (m_wait_res) begin
        if (!busy) begin
          m_wait_res = 0;
          if (takes(m_cond, m_z)) m_wait_fetch = 1;
          else m_active = 0;
        end
      end else if (m_wait_fetch) begin
        if (rdy) begin
          m_wait_fetch = 0;
          m_flush_left = int'(FL);
        end
      end else if (m_flush_left > 0) begin
        m_flush_left--;
        if (m_flush_left == 0) m_active = 0;
      end
      m_z = new_z;
    end
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 0, 0, 2'd0, 16'h0, rdy);
  endtask

  task automatic write_flag(input logic [15:0] v);
    step(0, 1, 1, v, 0, 0, 2'd0, 16'h0, 1);
  endtask

  initial begin
    reset = 1; alu_valid = 0; flag_we = 0; alu_result = '0; flag_busy = 0;
    br_req = 0; br_cond = '0; br_target = '0; fetch_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Flag updates: zero, non-zero, and an unqualified write.
    write_flag(16'h0000);
    write_flag(16'h0001);
    step(0, 1, 0, 16'h0000, 0, 0, 2'd0, 16'h0, 1);
    idle(1, 1);

    // Taken if-zero branch with fetch ready.
    write_flag(16'h0000);
    step(0, 0, 0, 16'h0, 0, 1, 2'b01, 16'h0040, 1);
    idle(6, 1);

    // Not-taken if-not-zero with Z set.
    step(0, 0, 0, 16'h0, 0, 1, 2'b10, 16'h0080, 1);
    idle(3, 1);

    // Busy flag write resolves the branch with the fresh flag.
    write_flag(16'h1234);
    step(0, 0, 0, 16'h0, 1, 1, 2'b01, 16'h00c0, 1);
    step(0, 0, 0, 16'h0, 1, 0, 2'd0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1, 0, 2'd0, 16'h0, 1);
    step(0, 1, 1, 16'h0, 1, 0, 2'd0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 0, 0, 2'd0, 16'h0, 1);
    idle(5, 1);

    // Fetch stalls five cycles before accepting.
    step(0, 0, 0, 16'h0, 0, 1, 2'b00, 16'hbeef, 0);
    idle(6, 0);
    idle(5, 1);

    // Reset while flushing abandons the branch.
    write_flag(16'h0000);
    step(0, 0, 0, 16'h0, 0, 1, 2'b00, 16'h1111, 1);
    idle(3, 1);
    step(1, 0, 0, 16'h0, 0, 0, 2'd0, 16'h0, 1);
    idle(3, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom),
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 1) == 1,
           2'($urandom),
           16'($urandom),
           $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
